// File: rtl/gray_decoder_monitor.sv
// rtl/gray_decoder_monitor.sv - gray-code receive decoder with step-legality monitor
// Optional build macro GRAY_MON_RESYNC_EN: re-acquire reference after an illegal step.
module gray_decoder_monitor #(
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] Gray,
    output logic [WIDTH-1:0] Binary,
    output logic             Locked,
    output logic             Overflow,
    output logic             Error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_binary;
    logic             r_locked;
    logic             r_overflow;
    logic             r_error;

    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_inc;
    logic             w_wrap;

    // Prefix-XOR from the MSB down turns gray into binary.
    always_comb begin
        w_dec            = '0;
        w_dec[WIDTH-1]   = Gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            w_dec[i] = w_dec[i+1] ^ Gray[i];
        end
    end

    assign w_inc  = r_binary + {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_wrap = &r_binary;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_binary   <= '0;
            r_locked   <= 1'b0;
            r_overflow <= 1'b0;
            r_error    <= 1'b0;
        end else if (En) begin
            case (r_state)
                IDLE: begin
                    r_binary <= w_dec;
                    r_locked <= 1'b1;
                    r_state  <= TRACK;
                end
                TRACK: begin
                    if (w_dec == r_binary) begin
                        r_state <= TRACK;
                    end else if (w_dec == w_inc) begin
                        r_binary <= w_dec;
                        if (w_wrap) begin
                            r_overflow <= 1'b1;
                        end
                    end else begin
                        r_error  <= 1'b1;
                        r_locked <= 1'b0;
                        r_state  <= ERR;
                    end
                end
                ERR: begin
`ifdef GRAY_MON_RESYNC_EN
                    r_binary <= w_dec;
                    r_locked <= 1'b1;
                    r_state  <= TRACK;
`else
                    r_state  <= ERR;
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Binary   = r_binary;
    assign Locked   = r_locked;
    assign Overflow = r_overflow;
    assign Error    = r_error;

endmodule

// File: tb/tb_gray_decoder_monitor.sv
// tb/tb_gray_decoder_monitor.sv - scoreboard bench for gray_decoder_monitor (WIDTH=3)
module tb_gray_decoder_monitor;

    localparam int W = 3;

    typedef struct {
        logic [W-1:0] bin;
        logic         lk;
        logic         ov;
        logic         er;
        string        tag;
    } exp_t;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         En = 1'b0;
    logic [W-1:0] Gray = '0;
    logic [W-1:0] Binary;
    logic         Locked;
    logic         Overflow;
    logic         Error;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    gray_decoder_monitor #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .En       (En),
        .Gray     (Gray),
        .Binary   (Binary),
        .Locked   (Locked),
        .Overflow (Overflow),
        .Error    (Error)
    );

    always #5 Clk = ~Clk;

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic step(input logic rst, input logic en, input logic [W-1:0] g,
                        input logic [W-1:0] bin, input logic lk, input logic ov,
                        input logic er, input string tag);
        exp_t e;
        exp_t got;
        logic [W+2:0] obs;
        logic [W+2:0] req;
        Reset = rst;
        En    = en;
        Gray  = g;
        e.bin = bin; e.lk = lk; e.ov = ov; e.er = er; e.tag = tag;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        got = sb.pop_front();
        obs = {Binary, Locked, Overflow, Error};
        req = {got.bin, got.lk, got.ov, got.er};
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed bin/lk/ov/er=%b required %b", got.tag, obs, req);
        end
    endtask

    initial begin
        @(posedge Clk);
        #1;
        step(1, 0, 3'b000, 3'd0, 0, 0, 0, "reset_state");

        // 1: full ascending sequence
        for (int i = 0; i < 8; i++) begin
            step(0, 1, to_gray(W'(i)), W'(i), 1, 0, 0, $sformatf("seq_%0d", i));
        end

        // 2: wrap and continue
        step(0, 1, 3'b000, 3'd0, 1, 1, 0, "wrap_0");
        step(0, 1, 3'b001, 3'd1, 1, 1, 0, "after_wrap_1");
        step(0, 1, 3'b011, 3'd2, 1, 1, 0, "after_wrap_2");

        // 3: hold is legal
        step(1, 0, 3'b000, 3'd0, 0, 0, 0, "reset3");
        step(0, 1, 3'b001, 3'd1, 1, 0, 0, "lock_on_1");
        step(0, 1, 3'b011, 3'd2, 1, 0, 0, "step_2");
        step(0, 1, 3'b011, 3'd2, 1, 0, 0, "hold_2");
        step(0, 1, 3'b010, 3'd3, 1, 0, 0, "step_3");

        // 4: illegal jump, then behaviour in ERR
        step(1, 0, 3'b000, 3'd0, 0, 0, 0, "reset4");
        step(0, 1, 3'b001, 3'd1, 1, 0, 0, "lock4_on_1");
        step(0, 1, 3'b110, 3'd1, 0, 0, 1, "illegal_jump");
`ifdef GRAY_MON_RESYNC_EN
        step(0, 1, 3'b111, 3'd5, 1, 0, 1, "resync_5");
        step(0, 1, 3'b101, 3'd6, 1, 0, 1, "resync_track_6");
`else
        step(0, 1, 3'b111, 3'd1, 0, 0, 1, "err_frozen");
        step(0, 1, 3'b101, 3'd1, 0, 0, 1, "err_frozen2");
`endif

        // 5: reset beats En mid-run, then fresh reference
        step(1, 0, 3'b000, 3'd0, 0, 0, 0, "reset5");
        step(0, 1, 3'b100, 3'd7, 1, 0, 0, "lock_on_7");
        step(0, 1, 3'b000, 3'd0, 1, 1, 0, "wrap5");
        step(1, 1, 3'b111, 3'd0, 0, 0, 0, "reset_over_en");
        step(0, 1, 3'b011, 3'd2, 1, 0, 0, "relock_2");

        // 6: En low ignores Gray entirely
        for (int i = 0; i < 10; i++) begin
            step(0, 0, W'($urandom_range(0, 7)), 3'd2, 1, 0, 0, $sformatf("en_low_%0d", i));
        end
        step(0, 1, 3'b010, 3'd3, 1, 0, 0, "resume_3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
